// File: rtl/ctrl_fsm_v2.sv
// ctrl_fsm_v2: multi-cycle control sequencer for the RISC core.
// Drives IR/PC/regfile enables, handles fetch and data-memory waits with a
// timeout, raises traps with RISC-V cause codes, and optionally halts.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   imem_busy             instruction memory not ready
//   decoder_illegal,
//   is_ebreak, is_ecall   decode results, sampled in DECODE
//   div_busy              divider iterating, sampled in EXECUTE
//   is_load_store,
//   is_store              memory-access class of current instruction
//   mem_busy, mem_err     data memory handshake, sampled in MEM_WAIT
//   state                 current state encoding
//   ir_en, pc_en, rf_we   datapath enables
//   trap_valid            one-cycle trap pulse
//   trap_cause            cause of the most recent trap
//   cycle_cnt,
//   instret_cnt           performance counters
// Optional feature: define CTRL_FSM_PERF_CNT_EN to build the counters;
// otherwise both counter ports read as zero.

module ctrl_fsm_v2 #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TRAP_HALT   = 0,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_busy,
    input  logic             decoder_illegal,
    input  logic             is_ebreak,
    input  logic             is_ecall,
    input  logic             div_busy,
    input  logic             is_load_store,
    input  logic             is_store,
    input  logic             mem_busy,
    input  logic             mem_err,
    output logic [2:0]       state,
    output logic             ir_en,
    output logic             pc_en,
    output logic             rf_we,
    output logic             trap_valid,
    output logic [3:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH       = 3'd0,
        S_DECODE      = 3'd1,
        S_EXECUTE     = 3'd2,
        S_WRITE_BACK  = 3'd3,
        S_MEM_WAIT    = 3'd4,
        S_TRAP        = 3'd5,
        S_IFETCH_WAIT = 3'd6,
        S_HALT        = 3'd7
    } state_t;

    localparam logic [3:0] C_IFETCH  = 4'd1;
    localparam logic [3:0] C_ILLEGAL = 4'd2;
    localparam logic [3:0] C_EBREAK  = 4'd3;
    localparam logic [3:0] C_LOAD    = 4'd5;
    localparam logic [3:0] C_STORE   = 4'd7;
    localparam logic [3:0] C_ECALL   = 4'd11;

    // A zero timeout still needs a legal one-bit timer.
    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST =
        (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;
    localparam logic TO_EN = (MEM_TIMEOUT > 0);
    localparam logic HALT_EN = (TRAP_HALT != 0);

    state_t          state_q;
    state_t          state_n;
    logic [3:0]      cause_q;
    logic [3:0]      cause_n;
    logic [TW-1:0]   timer_q;
    logic            timeout;
    logic            in_wait;
    logic [3:0]      mem_cause;

    assign state      = state_q;
    assign trap_cause = cause_q;

    assign in_wait   = (state_q == S_IFETCH_WAIT) ||
                       (state_q == S_MEM_WAIT);
    assign timeout   = TO_EN && (timer_q == T_LAST);
    assign mem_cause = is_store ? C_STORE : C_LOAD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cause_q <= 4'd0;
            timer_q <= '0;
        end else begin
            state_q <= state_n;
            cause_q <= cause_n;
            // Zero outside the wait states, so every entry starts at 0.
            if (in_wait)
                timer_q <= timer_q + 1'b1;
            else
                timer_q <= '0;
        end
    end

    always_comb begin
        state_n    = state_q;
        cause_n    = cause_q;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        rf_we      = 1'b0;
        trap_valid = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_en   = !imem_busy;
                state_n = imem_busy ? S_IFETCH_WAIT : S_DECODE;
            end
            S_IFETCH_WAIT: begin
                ir_en = !imem_busy;
                // Completion beats a coincident timeout.
                if (!imem_busy) begin
                    state_n = S_DECODE;
                end else if (timeout) begin
                    state_n = S_TRAP;
                    cause_n = C_IFETCH;
                end
            end
            S_DECODE: begin
                if (decoder_illegal) begin
                    state_n = S_TRAP;
                    cause_n = C_ILLEGAL;
                end else if (is_ebreak) begin
                    state_n = S_TRAP;
                    cause_n = C_EBREAK;
                end else if (is_ecall) begin
                    state_n = S_TRAP;
                    cause_n = C_ECALL;
                end else begin
                    state_n = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (div_busy)
                    state_n = S_EXECUTE;
                else if (is_load_store)
                    state_n = S_MEM_WAIT;
                else
                    state_n = S_WRITE_BACK;
            end
            S_MEM_WAIT: begin
                if (mem_err) begin
                    state_n = S_TRAP;
                    cause_n = mem_cause;
                end else if (!mem_busy) begin
                    state_n = S_WRITE_BACK;
                end else if (timeout) begin
                    state_n = S_TRAP;
                    cause_n = mem_cause;
                end
            end
            S_WRITE_BACK: begin
                rf_we   = !is_store;
                pc_en   = 1'b1;
                state_n = S_FETCH;
            end
            S_TRAP: begin
                pc_en      = 1'b1;
                trap_valid = 1'b1;
                state_n    = HALT_EN ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

`ifdef CTRL_FSM_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_HALT)
                cyc_q <= cyc_q + 1'b1;
            // WRITE_BACK always leaves to FETCH: one retirement.
            if (state_q == S_WRITE_BACK)
                ret_q <= ret_q + 1'b1;
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_fsm_v2.sv
// tb_ctrl_fsm_v2: directed bench for ctrl_fsm_v2.
// Three instances: timeout 16, timeout 4, and timeout 2 with halt-on-trap.

module tb_ctrl_fsm_v2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic imem_busy, decoder_illegal, is_ebreak, is_ecall;
    logic div_busy, is_load_store, is_store, mem_busy, mem_err;

    logic [2:0]  st [3];
    logic        ir [3];
    logic        pc [3];
    logic        we [3];
    logic        tv [3];
    logic [3:0]  tc [3];
    logic [31:0] cc [3];
    logic [31:0] ic [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_fsm_v2 #(.MEM_TIMEOUT(16), .TRAP_HALT(0), .CNT_W(32)) u0 (
        .clk(clk), .reset(reset), .imem_busy(imem_busy),
        .decoder_illegal(decoder_illegal), .is_ebreak(is_ebreak),
        .is_ecall(is_ecall), .div_busy(div_busy),
        .is_load_store(is_load_store), .is_store(is_store),
        .mem_busy(mem_busy), .mem_err(mem_err),
        .state(st[0]), .ir_en(ir[0]), .pc_en(pc[0]), .rf_we(we[0]),
        .trap_valid(tv[0]), .trap_cause(tc[0]),
        .cycle_cnt(cc[0]), .instret_cnt(ic[0]));

    ctrl_fsm_v2 #(.MEM_TIMEOUT(4), .TRAP_HALT(0), .CNT_W(32)) u1 (
        .clk(clk), .reset(reset), .imem_busy(imem_busy),
        .decoder_illegal(decoder_illegal), .is_ebreak(is_ebreak),
        .is_ecall(is_ecall), .div_busy(div_busy),
        .is_load_store(is_load_store), .is_store(is_store),
        .mem_busy(mem_busy), .mem_err(mem_err),
        .state(st[1]), .ir_en(ir[1]), .pc_en(pc[1]), .rf_we(we[1]),
        .trap_valid(tv[1]), .trap_cause(tc[1]),
        .cycle_cnt(cc[1]), .instret_cnt(ic[1]));

    ctrl_fsm_v2 #(.MEM_TIMEOUT(2), .TRAP_HALT(1), .CNT_W(32)) u2 (
        .clk(clk), .reset(reset), .imem_busy(imem_busy),
        .decoder_illegal(decoder_illegal), .is_ebreak(is_ebreak),
        .is_ecall(is_ecall), .div_busy(div_busy),
        .is_load_store(is_load_store), .is_store(is_store),
        .mem_busy(mem_busy), .mem_err(mem_err),
        .state(st[2]), .ir_en(ir[2]), .pc_en(pc[2]), .rf_we(we[2]),
        .trap_valid(tv[2]), .trap_cause(tc[2]),
        .cycle_cnt(cc[2]), .instret_cnt(ic[2]));

    // Counter value expected for this build.
    function automatic logic [31:0] pexp(input int v);
`ifdef CTRL_FSM_PERF_CNT_EN
        return 32'(v);
`else
        return 32'd0 & 32'(v);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        imem_busy = 0; decoder_illegal = 0; is_ebreak = 0;
        is_ecall = 0; div_busy = 0; is_load_store = 0;
        is_store = 0; mem_busy = 0; mem_err = 0;
    endtask

    task automatic do_reset();
        clr_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (st[0] !== 3'd0) begin
            errors++; $display("FAIL rst_state got %0d want 0", st[0]);
        end
        checks++;
        if (tc[0] !== 4'd0) begin
            errors++; $display("FAIL rst_cause got %0d want 0", tc[0]);
        end
        checks++;
        if ({pc[0], we[0], tv[0]} !== 3'b000) begin
            errors++;
            $display("FAIL rst_en got %b want 000",
                     {pc[0], we[0], tv[0]});
        end
        checks++;
        if (ir[0] !== 1'b1) begin
            errors++; $display("FAIL rst_ir got %b want 1", ir[0]);
        end
        imem_busy = 1'b1;
        #1;
        checks++;
        if (ir[0] !== 1'b0) begin
            errors++; $display("FAIL rst_ir_busy got %b want 0", ir[0]);
        end
        imem_busy = 1'b0;
        checks++;
        if (cc[0] !== 32'd0 || ic[0] !== 32'd0) begin
            errors++;
            $display("FAIL rst_cnt got %0d/%0d want 0/0", cc[0], ic[0]);
        end
    endtask

    task automatic test_alu();
        logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        int nwe = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (st[0] !== exp_st[i]) begin
                errors++;
                $display("FAIL alu_seq%0d got %0d want %0d",
                         i, st[0], exp_st[i]);
            end
            if (we[0] === 1'b1) nwe++;
            if (i < 4) tick();
        end
        checks++;
        if (nwe !== 1) begin
            errors++; $display("FAIL alu_rf_we got %0d want 1", nwe);
        end
        checks++;
        if (ic[0] !== pexp(1)) begin
            errors++;
            $display("FAIL alu_instret got %0d want %0d", ic[0], pexp(1));
        end
        checks++;
        if (cc[0] !== pexp(4)) begin
            errors++;
            $display("FAIL alu_cycle got %0d want %0d", cc[0], pexp(4));
        end
    endtask

    task automatic test_load_wait();
        int nmw = 0;
        int ntv = 0;
        do_reset();
        is_load_store = 1'b1;
        tick();
        tick();
        mem_busy = 1'b1;
        tick();
        for (int g = 0; g < 10; g++) begin
            if (st[0] !== 3'd4) break;
            nmw++;
            if (tv[0] === 1'b1) ntv++;
            if (nmw == 3) mem_busy = 1'b0;
            tick();
        end
        checks++;
        if (nmw !== 3) begin
            errors++; $display("FAIL load_mw got %0d want 3", nmw);
        end
        checks++;
        if (st[0] !== 3'd3 || we[0] !== 1'b1 || ntv !== 0) begin
            errors++;
            $display("FAIL load_wb got st%0d we%b tv%0d want st3 we1 tv0",
                     st[0], we[0], ntv);
        end
    endtask

    task automatic test_store_timeout();
        int nmw = 0;
        int nwe = 0;
        do_reset();
        is_load_store = 1'b1;
        is_store = 1'b1;
        mem_busy = 1'b1;
        tick();
        tick();
        tick();
        for (int g = 0; g < 10; g++) begin
            if (st[1] !== 3'd4) break;
            nmw++;
            if (we[1] === 1'b1) nwe++;
            tick();
        end
        checks++;
        if (nmw !== 4) begin
            errors++; $display("FAIL st_to_mw got %0d want 4", nmw);
        end
        checks++;
        if (st[1] !== 3'd5 || tc[1] !== 4'd7) begin
            errors++;
            $display("FAIL st_to_trap got st%0d c%0d want st5 c7",
                     st[1], tc[1]);
        end
        checks++;
        if (tv[1] !== 1'b1 || pc[1] !== 1'b1 || nwe !== 0) begin
            errors++;
            $display("FAIL st_to_en got tv%b pc%b we%0d want 1 1 0",
                     tv[1], pc[1], nwe);
        end
        tick();
        checks++;
        if (st[1] !== 3'd0 || tv[1] !== 1'b0) begin
            errors++;
            $display("FAIL st_to_after got st%0d tv%b want st0 tv0",
                     st[1], tv[1]);
        end
        checks++;
        if (ic[1] !== pexp(0)) begin
            errors++;
            $display("FAIL st_to_instret got %0d want 0", ic[1]);
        end
    endtask

    // Completion in the timeout cycle must win over the trap.
    task automatic test_timeout_edge();
        int nmw = 0;
        do_reset();
        is_load_store = 1'b1;
        mem_busy = 1'b1;
        tick();
        tick();
        tick();
        for (int g = 0; g < 10; g++) begin
            if (st[1] !== 3'd4) break;
            nmw++;
            if (nmw == 4) mem_busy = 1'b0;
            tick();
        end
        checks++;
        if (nmw !== 4 || st[1] !== 3'd3 || tc[1] !== 4'd0) begin
            errors++;
            $display("FAIL to_edge got mw%0d st%0d c%0d want 4 3 0",
                     nmw, st[1], tc[1]);
        end
    endtask

    task automatic test_decode_halt();
        logic [31:0] c_frz;
        do_reset();
        decoder_illegal = 1'b1;
        is_ecall = 1'b1;
        tick();
        tick();
        checks++;
        if (st[2] !== 3'd5 || tc[2] !== 4'd2 || tv[2] !== 1'b1) begin
            errors++;
            $display("FAIL dec_trap got st%0d c%0d tv%b want 5 2 1",
                     st[2], tc[2], tv[2]);
        end
        checks++;
        if (st[0] !== 3'd5 || tc[0] !== 4'd2) begin
            errors++;
            $display("FAIL dec_trap0 got st%0d c%0d want 5 2",
                     st[0], tc[0]);
        end
        tick();
        checks++;
        if (st[2] !== 3'd7 || st[0] !== 3'd0) begin
            errors++;
            $display("FAIL dec_next got h%0d f%0d want 7 0",
                     st[2], st[0]);
        end
        c_frz = cc[2];
        repeat (5) tick();
        checks++;
        if (st[2] !== 3'd7 || pc[2] !== 1'b0 || tv[2] !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold got st%0d pc%b tv%b want 7 0 0",
                     st[2], pc[2], tv[2]);
        end
        checks++;
        if (cc[2] !== pexp(3) || cc[2] !== c_frz) begin
            errors++;
            $display("FAIL halt_cycle got %0d want %0d", cc[2], pexp(3));
        end
        do_reset();
        checks++;
        if (st[2] !== 3'd0 || tc[2] !== 4'd0) begin
            errors++;
            $display("FAIL halt_reset got st%0d c%0d want 0 0",
                     st[2], tc[2]);
        end
    endtask

    task automatic test_causes();
        logic [2:0] vin [3] = '{3'b011, 3'b001, 3'b110};
        logic [3:0] vexp [3] = '{4'd3, 4'd11, 4'd2};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            {decoder_illegal, is_ebreak, is_ecall} = vin[i];
            tick();
            tick();
            checks++;
            if (st[0] !== 3'd5 || tc[0] !== vexp[i]) begin
                errors++;
                $display("FAIL cause%0d got st%0d c%0d want 5 %0d",
                         i, st[0], tc[0], vexp[i]);
            end
        end
    endtask

    task automatic test_ifetch_wait();
        int nir = 0;
        do_reset();
        imem_busy = 1'b1;
        #1;
        if (ir[0] === 1'b1) nir++;
        tick();
        checks++;
        if (st[0] !== 3'd6) begin
            errors++; $display("FAIL ifw1 got %0d want 6", st[0]);
        end
        if (ir[0] === 1'b1) nir++;
        tick();
        checks++;
        if (st[0] !== 3'd6) begin
            errors++; $display("FAIL ifw2 got %0d want 6", st[0]);
        end
        imem_busy = 1'b0;
        #1;
        if (ir[0] === 1'b1) nir++;
        tick();
        if (ir[0] === 1'b1) nir++;
        checks++;
        if (st[0] !== 3'd1 || nir !== 1) begin
            errors++;
            $display("FAIL ifw_dec got st%0d ir%0d want 1 1", st[0], nir);
        end
    endtask

    task automatic test_ifetch_timeout();
        do_reset();
        imem_busy = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (st[2] !== 3'd5 || tc[2] !== 4'd1) begin
            errors++;
            $display("FAIL ifw_to got st%0d c%0d want 5 1",
                     st[2], tc[2]);
        end
        checks++;
        if (st[0] !== 3'd6) begin
            errors++; $display("FAIL ifw_to16 got %0d want 6", st[0]);
        end
        do_reset();
    endtask

    task automatic test_mem_err();
        logic [3:0] vexp [2] = '{4'd5, 4'd7};
        for (int i = 0; i < 2; i++) begin
            do_reset();
            is_load_store = 1'b1;
            is_store = (i == 1);
            tick();
            tick();
            mem_err = 1'b1;
            tick();
            tick();
            checks++;
            if (st[0] !== 3'd5 || tc[0] !== vexp[i] || we[0] !== 1'b0) begin
                errors++;
                $display("FAIL mem_err%0d got st%0d c%0d want 5 %0d",
                         i, st[0], tc[0], vexp[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int nmw = 0;
        do_reset();
        is_ecall = 1'b1;
        tick();
        tick();
        clr_in();
        tick();
        is_load_store = 1'b1;
        mem_busy = 1'b1;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (st[0] !== 3'd4 || tc[0] !== 4'd11) begin
            errors++;
            $display("FAIL mid_pre got st%0d c%0d want 4 11",
                     st[0], tc[0]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (st[0] !== 3'd0 || tc[0] !== 4'd0) begin
            errors++;
            $display("FAIL mid_rst got st%0d c%0d want 0 0",
                     st[0], tc[0]);
        end
        checks++;
        if (cc[0] !== 32'd0 || ic[0] !== 32'd0) begin
            errors++;
            $display("FAIL mid_cnt got %0d/%0d want 0/0", cc[0], ic[0]);
        end
        tick();
        tick();
        tick();
        for (int g = 0; g < 10; g++) begin
            if (st[1] !== 3'd4) break;
            nmw++;
            tick();
        end
        checks++;
        if (nmw !== 4 || st[1] !== 3'd5) begin
            errors++;
            $display("FAIL mid_timer got mw%0d st%0d want 4 5",
                     nmw, st[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_st [9] =
            '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        int bad = 0;
        do_reset();
        div_busy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (st[0] !== exp_st[i]) bad++;
            if (i < 8) tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL b2b_seq got %0d bad want 0", bad);
        end
        checks++;
        if (ic[0] !== pexp(2) || cc[0] !== pexp(8)) begin
            errors++;
            $display("FAIL b2b_cnt got %0d/%0d want %0d/%0d",
                     ic[0], cc[0], pexp(2), pexp(8));
        end
    endtask

    task automatic test_div_stall();
        do_reset();
        div_busy = 1'b1;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (st[0] !== 3'd2) begin
            errors++; $display("FAIL div_hold got %0d want 2", st[0]);
        end
        div_busy = 1'b0;
        tick();
        checks++;
        if (st[0] !== 3'd3) begin
            errors++; $display("FAIL div_done got %0d want 3", st[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        test_reset();
        test_alu();
        test_load_wait();
        test_store_timeout();
        test_timeout_edge();
        test_decode_halt();
        test_causes();
        test_ifetch_wait();
        test_ifetch_timeout();
        test_mem_err();
        test_mid_reset();
        test_back_to_back();
        test_div_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
